// File: rtl/uart_rx_done_monitor.sv
// uart_rx_done_monitor: simulation-side 8N1 UART receiver that watches the
// received byte stream for PASS/FAIL end-of-test tokens and raises sticky
// sim_done / sim_pass flags.
// Optional: define UART_RX_PARITY_EN for 8E1 frames with a parity_err output.
module uart_rx_done_monitor #(
  parameter int unsigned CLKS_PER_BIT = 1736,
  parameter int unsigned TOKEN_LEN    = 4,
  parameter logic [8*TOKEN_LEN-1:0] PASS_TOKEN = "PASS",
  parameter logic [8*TOKEN_LEN-1:0] FAIL_TOKEN = "FAIL"
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [15:0] byte_count,
  output logic        sim_done,
  output logic        sim_pass
`ifdef UART_RX_PARITY_EN
  ,
  output logic        parity_err
`endif
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TW = 8 * TOKEN_LEN;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;
`endif

  state_t         state;
  logic           rx_meta;
  logic           rx_s;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic [TW-1:0]  tok;
  logic           tok_new;
`ifdef UART_RX_PARITY_EN
  logic           par_bad;
`endif

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame receiver FSM with registered byte outputs and token shift
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      byte_count <= '0;
      tok        <= '0;
      tok_new    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      tok_new   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= (^shreg) ^ rx_s;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              // Framing error outranks parity error
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end else begin
              state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else begin
`else
              begin
`endif
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                byte_count <= byte_count + 16'd1;
                tok        <= TW'({tok, shreg});
                tok_new    <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Compare the token window one cycle after each shift; first match sticks
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sim_done <= 1'b0;
      sim_pass <= 1'b0;
    end else if (tok_new && !sim_done) begin
      if (tok == PASS_TOKEN) begin
        sim_done <= 1'b1;
        sim_pass <= 1'b1;
      end else if (tok == FAIL_TOKEN) begin
        sim_done <= 1'b1;
        sim_pass <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_done_monitor.sv
// Randomized self-checking bench for uart_rx_done_monitor (CLKS_PER_BIT=16).
module tb_uart_rx_done_monitor;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic [15:0] byte_count;
  logic        sim_done;
  logic        sim_pass;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif

  uart_rx_done_monitor #(
    .CLKS_PER_BIT(CPB),
    .TOKEN_LEN   (4),
    .PASS_TOKEN  ("PASS"),
    .FAIL_TOKEN  ("FAIL")
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .byte_count(byte_count),
    .sim_done  (sim_done),
    .sim_pass  (sim_pass)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Reference model state
  logic [7:0]  exp_q[$];
  int unsigned m_count;
  logic [31:0] win;
  bit          m_done, m_pass, done_chk;
  int unsigned fe_cnt, fe_exp, pe_cnt, pe_exp;
  logic [7:0]  mb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_count = 0; win = '0; m_done = 0; m_pass = 0; done_chk = 0;
    fe_cnt = 0; fe_exp = 0; pe_cnt = 0; pe_exp = 0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // One frame; stop_ok=0 holds the line low for the stop bit plus 'hold' clocks
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int hold);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit((^b) ^ ~par_ok);
    if (stop_ok) begin
      if (par_ok || !PAR) begin
        exp_q.push_back(b);
        m_count++;
      end else begin
        pe_exp++;
      end
      drive_bit(1'b1);
    end else begin
      fe_exp++;
      uart_rx = 1'b0;
      repeat (CPB + hold) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, 1'b1, 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(byte_count), m_count & 32'hFFFF);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_frame_err_n"}, fe_cnt, fe_exp);
    check({tag, "_done"}, 32'(sim_done), 32'(m_done));
    check({tag, "_pass"}, 32'(sim_pass), 32'(m_pass));
    if (PAR) check({tag, "_parity_err_n"}, pe_cnt, pe_exp);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_byte_count", 32'(byte_count), 0);
    check("rst_sim_done", 32'(sim_done), 0);
    check("rst_sim_pass", 32'(sim_pass), 0);
`ifdef UART_RX_PARITY_EN
    check("rst_parity_err", 32'(parity_err), 0);
`endif
  endtask

  // Output monitor: byte order, flag timing relative to rx_valid, error pulses
  always @(negedge clk) begin
    if (resetn) begin
      if (done_chk) begin
        check("sim_done_after", 32'(sim_done), 32'(m_done));
        if (m_done) check("sim_pass_after", 32'(sim_pass), 32'(m_pass));
        done_chk = 0;
      end
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          check("rx_valid_unexpected", 32'(rx_valid), 0);
        end else begin
          mb = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(mb));
          check("sim_done_before", 32'(sim_done), 32'(m_done));
          win = {win[23:0], mb};
          if (!m_done) begin
            if (win == "PASS") begin m_done = 1; m_pass = 1; end
            else if (win == "FAIL") begin m_done = 1; m_pass = 0; end
          end
          done_chk = 1;
        end
      end
      if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
    end
  end

  logic [7:0] rb;
  bit         rs, rp;
  int         rk;

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    resetn = 1'b1;
    @(negedge clk);

    // Single byte
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check("a5_data", 32'(rx_data), 32'hA5);
    check_state("a5");

    // PASS token then FAIL is ignored
    apply_reset();
    send_str("xxPASS\n");
    check_state("pass");
    send_str("FAIL");
    check("count_11", 32'(byte_count), 11);
    check_state("pass_then_fail");

    // FAIL token, then reset clears everything
    apply_reset();
    send_str("FAIL");
    check_state("fail");
    apply_reset();
    check_reset_outputs();

    // Start-bit glitch
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_state("glitch");
    send_frame(8'h3C, 1'b1, 1'b1, 0);
    check("glitch_then_3c", 32'(rx_data), 32'h3C);
    check_state("after_glitch");

    // Stop bit low, line held low
    send_frame(8'h55, 1'b0, 1'b1, 40);
    check_state("break");
    send_frame(8'h55, 1'b1, 1'b1, 0);
    check_state("after_break");

    // Reset during bit 3 of 0xFF, released mid-frame
    apply_reset();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    uart_rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    apply_reset();
    repeat (6 * CPB) @(negedge clk);
    check_state("mid_reset");
    send_frame(8'h12, 1'b1, 1'b1, 0);
    check("mid_reset_12", 32'(rx_data), 32'h12);
    check_state("after_mid_reset");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 0);
    check_state("parity_bad");
`endif

    // Randomized traffic with occasional tokens and errors
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      rk = $urandom_range(0, 9);
      if (rk == 0) begin
        send_str(($urandom_range(0, 1) == 1) ? "PASS" : "FAIL");
      end else begin
        rb = 8'($urandom);
        rs = ($urandom_range(0, 7) != 0);
        rp = PAR ? ($urandom_range(0, 5) != 0) : 1'b1;
        send_frame(rb, rs, rp, $urandom_range(0, 30));
      end
      check_state("random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
